// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM card/PIN blocks.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    GRANTED = 3'd3,
    LOCKED  = 3'd4
  } pin_state_t;

  localparam int BCD_MAX       = 9;
  localparam int DEF_PIN_LEN   = 4;
  localparam int DEF_MAX_TRIES = 3;

endpackage

// File: rtl/pin_verifier_if.sv
// Keypad/card bus of pin_verifier, plus debug visibility of FSM state and digit count.
interface pin_verifier_if #(
  parameter int PIN_LEN = 4
);
  import atm_pkg::*;

  localparam int CW = $clog2(PIN_LEN + 1);

  // digit_valid is a one-cycle strobe with no ready: the verifier either takes the
  // digit on that edge or drops it (wrong state, non-BCD value, or card pulled).
  logic                   card;
  logic                   digit_valid;
  logic [3:0]             digit;
  logic [4*PIN_LEN-1:0]   stored_pin;
  logic                   PIN;
  logic                   pin_err;
  logic                   card_retained;
  logic [1:0]             attempts_left;
  pin_state_t             state;
  logic [CW-1:0]          count;

  modport master (
    output card, digit_valid, digit, stored_pin,
    input  PIN, pin_err, card_retained, attempts_left, state, count
  );

  modport slave (
    input  card, digit_valid, digit, stored_pin,
    output PIN, pin_err, card_retained, attempts_left, state, count
  );

endinterface

// File: rtl/pin_shift_buffer.sv
// BCD shift register for keypad digits; first digit ends up most significant.
module pin_shift_buffer #(
  parameter int PIN_LEN = 4,
  parameter int CW      = $clog2(PIN_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift,
  input  logic [3:0]           digit,
  output logic [4*PIN_LEN-1:0] buffer,
  output logic [CW-1:0]        count,
  output logic                 full
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      buffer <= '0;
      count  <= '0;
    end else if (shift) begin
      buffer <= {buffer[4*PIN_LEN-5:0], digit};
      count  <= count + 1'b1;
    end
  end

  assign full = (count == CW'(PIN_LEN));

endmodule

// File: rtl/pin_verifier.sv
// PIN entry verifier: collects BCD digits, compares, grants or locks the card.
// Optional idle timeout between digits is built only with PIN_TIMEOUT_EN defined.
module pin_verifier
  import atm_pkg::*;
#(
  parameter int PIN_LEN        = DEF_PIN_LEN,
  parameter int MAX_TRIES      = DEF_MAX_TRIES,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic           clock,
  input  logic           reset,
  pin_verifier_if.slave  bus
);

  localparam int CW = $clog2(PIN_LEN + 1);

  if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_max_tries
    $error("pin_verifier: MAX_TRIES must be in 1..3");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pin_verifier: TIMEOUT_CYCLES must be at least 1");
  end

  pin_state_t           state, state_next;
  logic [1:0]           attempts_left;
  logic                 pin_err_q;
  logic                 buf_clear, buf_shift, fail, accept, timeout_hit;
  logic [4*PIN_LEN-1:0] buffer;
  logic [CW-1:0]        count;
  logic                 full;

  pin_shift_buffer #(.PIN_LEN(PIN_LEN), .CW(CW)) u_buf (
    .clock  (clock),
    .reset  (reset),
    .clear  (buf_clear),
    .shift  (buf_shift),
    .digit  (bus.digit),
    .buffer (buffer),
    .count  (count),
    .full   (full)
  );

  assign accept = bus.digit_valid && (bus.digit <= 4'(BCD_MAX));

`ifdef PIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts idle ENTRY cycles; fires on the edge that would make it TIMEOUT_CYCLES.
  assign timeout_hit = (state == ENTRY) && bus.card && !accept &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || state != ENTRY || !bus.card || accept || timeout_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    buf_clear  = 1'b0;
    buf_shift  = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE: begin
        buf_clear = 1'b1;
        if (bus.card) state_next = ENTRY;
      end
      ENTRY: begin
        if (!bus.card) begin
          state_next = IDLE;
          buf_clear  = 1'b1;
        end else if (accept) begin
          buf_shift = 1'b1;
          if (count == CW'(PIN_LEN - 1)) state_next = CHECK;
        end else if (timeout_hit) begin
          fail = 1'b1;
        end
      end
      CHECK: begin
        if (!bus.card) begin
          state_next = IDLE;
          buf_clear  = 1'b1;
        end else if (full && buffer == bus.stored_pin) begin
          state_next = GRANTED;
        end else begin
          fail = 1'b1;
        end
      end
      GRANTED: if (!bus.card) state_next = IDLE;
      LOCKED:  state_next = LOCKED;
      default: state_next = IDLE;
    endcase
    // A rejected entry (wrong PIN or timeout) restarts entry or locks on the last try.
    if (fail) begin
      buf_clear  = 1'b1;
      state_next = (attempts_left == 2'd1) ? LOCKED : ENTRY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      attempts_left <= 2'(MAX_TRIES);
      pin_err_q     <= 1'b0;
    end else begin
      pin_err_q <= fail;
      if (state_next == IDLE)
        attempts_left <= 2'(MAX_TRIES);
      else if (fail)
        attempts_left <= attempts_left - 2'd1;
    end
  end

  assign bus.PIN           = (state == GRANTED);
  assign bus.pin_err       = pin_err_q;
  assign bus.card_retained = (state == LOCKED);
  assign bus.attempts_left = attempts_left;
  assign bus.state         = state;
  assign bus.count         = count;

endmodule

// File: tb/tb_pin_verifier.sv
// Directed self-checking bench for pin_verifier (stored PIN 1234, three tries).
module tb_pin_verifier;
  import atm_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pin_verifier_if #(.PIN_LEN(4)) bus ();

  pin_verifier #(.PIN_LEN(4), .MAX_TRIES(3), .TIMEOUT_CYCLES(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    step(1);
    bus.digit_valid = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) press(p[4*i +: 4]);
  endtask

  initial begin
    bus.card        = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.stored_pin  = 16'h1234;
    reset           = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_state", bus.state, IDLE);
    check("rst_pin", bus.PIN, 0);
    check("rst_err", bus.pin_err, 0);
    check("rst_retained", bus.card_retained, 0);
    check("rst_attempts", bus.attempts_left, 3);

    // Correct PIN first time
    bus.card = 1'b1;
    step(1);
    check("entry_state", bus.state, ENTRY);
    check("entry_count", bus.count, 0);
    press(4'd1); press(4'd2); press(4'd3);
    check("count3", bus.count, 3);
    press(4'd4);
    check("check_state", bus.state, CHECK);
    check("check_pin_low", bus.PIN, 0);
    step(1);
    check("grant_pin", bus.PIN, 1);
    check("grant_attempts", bus.attempts_left, 3);
    check("grant_err", bus.pin_err, 0);
    bus.card = 1'b0;
    step(1);
    check("pull_state", bus.state, IDLE);
    check("pull_pin", bus.PIN, 0);

    // One wrong entry, then the right one
    bus.card = 1'b1;
    step(1);
    enter_pin(16'h1235);
    step(1);
    check("wrong_state", bus.state, ENTRY);
    check("wrong_err", bus.pin_err, 1);
    check("wrong_attempts", bus.attempts_left, 2);
    check("wrong_count", bus.count, 0);
    step(1);
    check("err_one_cycle", bus.pin_err, 0);
    enter_pin(16'h1234);
    step(1);
    check("retry_pin", bus.PIN, 1);
    check("retry_attempts", bus.attempts_left, 2);
    bus.card = 1'b0;
    step(1);
    check("retry_idle_attempts", bus.attempts_left, 3);

    // Three wrong entries lock the card
    bus.card = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      enter_pin(16'h9999);
      step(1);
      check("lock_err", bus.pin_err, 1);
      check("lock_attempts", bus.attempts_left, 32'(2 - i));
    end
    check("lock_state", bus.state, LOCKED);
    check("lock_retained", bus.card_retained, 1);
    check("lock_pin", bus.PIN, 0);
    bus.card = 1'b0;
    step(3);
    press(4'd1);
    check("lock_hold_state", bus.state, LOCKED);
    check("lock_hold_retained", bus.card_retained, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("unlock_state", bus.state, IDLE);
    check("unlock_retained", bus.card_retained, 0);
    check("unlock_attempts", bus.attempts_left, 3);

    // Non-BCD digit ignored; card pull beats a same-cycle digit
    bus.card = 1'b1;
    step(1);
    press(4'd1); press(4'hA); press(4'd2);
    check("nonbcd_count", bus.count, 2);
    check("nonbcd_err", bus.pin_err, 0);
    bus.card = 1'b0;
    press(4'd3);
    check("abort_state", bus.state, IDLE);
    check("abort_count", bus.count, 0);
    check("abort_err", bus.pin_err, 0);
    check("abort_attempts", bus.attempts_left, 3);

    // Reset mid-entry
    bus.card = 1'b1;
    step(1);
    press(4'd1); press(4'd2);
    check("mid_count", bus.count, 2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_state", bus.state, IDLE);
    check("mid_rst_count", bus.count, 0);

    // Digits in IDLE ignored; card pull during CHECK aborts without error
    bus.card = 1'b0;
    step(1);
    press(4'd5);
    check("idle_digit_state", bus.state, IDLE);
    check("idle_digit_count", bus.count, 0);
    bus.card = 1'b1;
    step(1);
    enter_pin(16'h1235);
    check("pre_abort_check", bus.state, CHECK);
    bus.card = 1'b0;
    step(1);
    check("check_abort_state", bus.state, IDLE);
    check("check_abort_err", bus.pin_err, 0);
    check("check_abort_attempts", bus.attempts_left, 3);

`ifdef PIN_TIMEOUT_EN
    bus.card = 1'b1;
    step(1);
    press(4'd1);
    step(9);
    check("tmo_early_err", bus.pin_err, 0);
    step(1);
    check("tmo_err", bus.pin_err, 1);
    check("tmo_attempts", bus.attempts_left, 2);
    check("tmo_state", bus.state, ENTRY);
    check("tmo_count", bus.count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
